// File: rtl/crc_stream_accum_pkg.sv
// Shared definitions for the streaming CRC accumulator: CRC-32 constants,
// FSM state encoding and beat-geometry helpers.
package crc_stream_accum_pkg;

   localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_CHECK  = 32'hCBF43926;  // CRC-32 of "123456789"

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int bytes_of(input int data_width);
      return data_width / 8;
   endfunction

   // Width of a field able to hold 0..BYTES inclusive.
   function automatic int nbytes_width(input int data_width);
      return $clog2(data_width / 8 + 1);
   endfunction

endpackage

// File: rtl/crc_stream_accum_byte_step.sv
// One byte of a reflected (right-shift) CRC: folds an 8-bit byte, LSB first,
// into the running CRC. Purely combinational.
module crc_stream_accum_byte_step
   import crc_stream_accum_pkg::*;
#(
   parameter int                   CRC_WIDTH = 32,
   parameter logic [CRC_WIDTH-1:0] POLY      = CRC32_POLY[CRC_WIDTH-1:0]
) (
   input  logic [CRC_WIDTH-1:0] crc_in,
   input  logic [7:0]           data_byte,
   output logic [CRC_WIDTH-1:0] crc_out
);

   logic [CRC_WIDTH-1:0] c;
   logic                 fb;

   always_comb begin
      // NOTE: blocking assignments here are deliberate; each loop iteration
      // must see the value produced by the previous one.
      c  = crc_in;
      fb = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ data_byte[i];
         c  = c >> 1;
         if (fb) c = c ^ POLY;
      end
      crc_out = c;
   end

endmodule

// File: rtl/crc_stream_accum.sv
// Streaming CRC accumulator: folds a multi-beat message (with optional
// partial final beat) into one CRC, one beat per clock.
module crc_stream_accum
   import crc_stream_accum_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          CRC_WIDTH  = 32,
   parameter logic [31:0] POLY       = CRC32_POLY,
   parameter logic [31:0] INIT       = CRC32_INIT,
   parameter logic [31:0] XOROUT     = CRC32_XOROUT
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic                                  s_valid,
   output logic                                  s_ready,
   input  logic [DATA_WIDTH-1:0]                 s_data,
   input  logic                                  s_last,
   input  logic [nbytes_width(DATA_WIDTH)-1:0]   s_nbytes,
   output logic                                  crc_valid,
   output logic [CRC_WIDTH-1:0]                  crc_value,
   output logic                                  busy,
   output logic [31:0]                           byte_count,
   output logic                                  err
);

   localparam int                   BYTES    = bytes_of(DATA_WIDTH);
   localparam int                   NB_W     = nbytes_width(DATA_WIDTH);
   localparam logic [NB_W-1:0]      BYTES_NB = NB_W'(BYTES);
   localparam logic [CRC_WIDTH-1:0] POLY_C   = POLY[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] INIT_C   = INIT[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] XOROUT_C = XOROUT[CRC_WIDTH-1:0];

   state_e               state, state_nx;
   logic [CRC_WIDTH-1:0] crc_reg;
   logic [CRC_WIDTH-1:0] tap [BYTES+1];
   logic [CRC_WIDTH-1:0] fold_crc;
   logic [NB_W-1:0]      fold_n;
   logic                 nbytes_over;
   logic                 accept;
   logic [32:0]          count_sum;
   logic [31:0]          count_nx;

   // Restart always wins over a beat presented in the same cycle.
   assign s_ready = (state == ST_RUN) && !start;
   assign busy    = (state == ST_RUN);
   assign accept  = s_valid && s_ready;

   // Tap k is the CRC after folding bytes 0..k-1 of the current beat.
   assign tap[0] = crc_reg;
   for (genvar k = 0; k < BYTES; k++) begin : g_step
      crc_stream_accum_byte_step #(
         .CRC_WIDTH (CRC_WIDTH),
         .POLY      (POLY_C)
      ) u_step (
         .crc_in    (tap[k]),
         .data_byte (s_data[8*k +: 8]),
         .crc_out   (tap[k+1])
      );
   end

   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves it unassigned and no latch is inferred.
      nbytes_over = 1'b0;
      fold_n      = BYTES_NB;
      if (s_last) begin
         if (s_nbytes > BYTES_NB) nbytes_over = 1'b1;
         else                     fold_n      = s_nbytes;
      end
   end

   always_comb begin
      fold_crc = tap[BYTES];
      for (int k = 0; k <= BYTES; k++) begin
         if (fold_n == NB_W'(k)) fold_crc = tap[k];
      end
   end

   // Saturating byte counter: the carry out of a 33-bit sum pins it at all-ones.
   always_comb begin
      count_sum = {1'b0, byte_count} + 33'(fold_n);
      count_nx  = count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: state_nx = ST_IDLE;
         ST_RUN:  if (accept && s_last) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_DONE;
         default: state_nx = ST_IDLE;
      endcase
      if (start) state_nx = ST_RUN;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst || start) begin
         crc_reg    <= INIT_C;
         crc_value  <= '0;
         crc_valid  <= 1'b0;
         byte_count <= '0;
         err        <= 1'b0;
      end else begin
         if (accept) begin
            crc_reg    <= fold_crc;
            byte_count <= count_nx;
            if (s_last) begin
               crc_value <= fold_crc ^ XOROUT_C;
               crc_valid <= 1'b1;
               if (nbytes_over) err <= 1'b1;
            end
         end
         if (s_valid && (state != ST_RUN)) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_crc_stream_accum.sv
// Self-checking bench for crc_stream_accum: table of messages driven back to
// back, results matched against a scoreboard, plus hand-written corner cases.
module tb_crc_stream_accum;
   import crc_stream_accum_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, s_valid, s_ready, s_last;
   logic [31:0] s_data;
   logic [2:0]  s_nbytes;
   logic        crc_valid, busy, err;
   logic [31:0] crc_value, byte_count;

   crc_stream_accum dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .s_nbytes   (s_nbytes),
      .crc_valid  (crc_valid),
      .crc_value  (crc_value),
      .busy       (busy),
      .byte_count (byte_count),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0][31:0] data;
      logic [1:0]       nbeats;
      logic [2:0]       nbytes;
      logic [31:0]      exp_crc;
      logic [31:0]      exp_count;
      logic             exp_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] crc;
      logic [31:0] count;
      logic        err;
      int          cyc;
   } exp_t;

   vec_t vecs [9];
   exp_t sb_q [$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic crc_valid_q = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every rising crc_valid must match the oldest pushed result.
   always @(negedge clk) begin
      if (!rst && crc_valid && !crc_valid_q) begin
         if (sb_q.size() == 0) begin
            check("unexpected_crc_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("crc_value", crc_value, e.crc);
            check("byte_count", byte_count, e.count);
            check("err", {31'd0, err}, {31'd0, e.err});
            check("latency_cycle", cyc, e.cyc);
         end
      end
      crc_valid_q <= crc_valid;
   end

   task automatic wait_drain();
      for (int i = 0; i < 10; i++) if (sb_q.size() != 0) @(negedge clk);
      check("sb_drain", sb_q.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   // Called at posedge+1; drives beats back to back with s_valid held high.
   task automatic run_vec(input vec_t v, input bit do_start);
      exp_t e;
      if (do_start) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int b = 0; b < int'(v.nbeats); b++) begin
         s_valid  = 1'b1;
         s_data   = v.data[b];
         s_last   = (b == int'(v.nbeats) - 1);
         s_nbytes = s_last ? v.nbytes : 3'd7;
         #1 check("s_ready_run", {31'd0, s_ready}, 32'd1);
         if (s_last) begin
            e.crc   = v.exp_crc;
            e.count = v.exp_count;
            e.err   = v.exp_err;
            e.cyc   = cyc + 1;
            sb_q.push_back(e);
         end
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      wait_drain();
   endtask

   initial begin
      vecs[0] = '{data: {32'h00000039, 32'h38373635, 32'h34333231}, nbeats: 2'd3, nbytes: 3'd1,
                  exp_crc: CRC32_CHECK, exp_count: 32'd9, exp_err: 1'b0};
      vecs[1] = '{data: {32'h0, 32'h0, 32'h00000000}, nbeats: 2'd1, nbytes: 3'd4,
                  exp_crc: 32'h2144DF1C, exp_count: 32'd4, exp_err: 1'b0};
      vecs[2] = '{data: {32'h0, 32'h0, 32'h12345678}, nbeats: 2'd1, nbytes: 3'd0,
                  exp_crc: 32'h00000000, exp_count: 32'd0, exp_err: 1'b0};
      vecs[3] = '{data: {32'h0, 32'h0, 32'h34333231}, nbeats: 2'd1, nbytes: 3'd5,
                  exp_crc: 32'h9BE3E0A3, exp_count: 32'd4, exp_err: 1'b1};
      vecs[4] = '{data: {32'h0, 32'h0, 32'h34333231}, nbeats: 2'd1, nbytes: 3'd4,
                  exp_crc: 32'h9BE3E0A3, exp_count: 32'd4, exp_err: 1'b0};
      vecs[5] = '{data: {32'h0, 32'hFFFFFFFF, 32'h34333231}, nbeats: 2'd2, nbytes: 3'd0,
                  exp_crc: 32'h9BE3E0A3, exp_count: 32'd4, exp_err: 1'b0};
      vecs[6] = '{data: {32'h0, 32'h0, 32'hA5A5A561}, nbeats: 2'd1, nbytes: 3'd1,
                  exp_crc: 32'hE8B7BE43, exp_count: 32'd1, exp_err: 1'b0};
      vecs[7] = '{data: {32'h0, 32'h0, 32'h11636261}, nbeats: 2'd1, nbytes: 3'd3,
                  exp_crc: 32'h352441C2, exp_count: 32'd3, exp_err: 1'b0};
      vecs[8] = '{data: {32'hAABBCC39, 32'h38373635, 32'h34333231}, nbeats: 2'd3, nbytes: 3'd1,
                  exp_crc: CRC32_CHECK, exp_count: 32'd9, exp_err: 1'b0};

      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      s_data = '0; s_nbytes = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
      check("rst_crc_value", crc_value, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_byte_count", byte_count, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd0);

      // Beat offered in IDLE is refused and flags a protocol error.
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = 32'h34333231; s_last = 1'b1; s_nbytes = 3'd4;
      #1 check("idle_s_ready", {31'd0, s_ready}, 32'd0);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      check("idle_err", {31'd0, err}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_no_count", byte_count, 32'd0);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b1);

      // Beat offered in DONE: refused, err set, result held.
      s_valid = 1'b1; s_data = 32'h0; s_last = 1'b1; s_nbytes = 3'd4;
      #1 check("done_s_ready", {31'd0, s_ready}, 32'd0);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
      check("done_err", {31'd0, err}, 32'd1);
      check("done_crc_valid", {31'd0, crc_valid}, 32'd1);
      check("done_crc_held", crc_value, CRC32_CHECK);
      check("done_count_held", byte_count, 32'd9);

      // Reset out of DONE clears result and sticky err.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_done_crc_valid", {31'd0, crc_valid}, 32'd0);
      check("rst_done_crc_value", crc_value, 32'd0);
      check("rst_done_err", {31'd0, err}, 32'd0);
      check("rst_done_count", byte_count, 32'd0);

      // Restart mid-message, with a beat coincident with start.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         s_valid = 1'b1; s_data = vecs[0].data[b]; s_last = 1'b0; s_nbytes = 3'd0;
         @(posedge clk); #1;
      end
      check("mid_count", byte_count, 32'd8);
      start = 1'b1; s_valid = 1'b1; s_data = 32'hDEADBEEF; s_last = 1'b1; s_nbytes = 3'd4;
      #1 check("restart_s_ready", {31'd0, s_ready}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      check("restart_count", byte_count, 32'd0);
      check("restart_crc_valid", {31'd0, crc_valid}, 32'd0);
      check("restart_busy", {31'd0, busy}, 32'd1);
      run_vec(vecs[0], 1'b0);

      // Reset mid-message abandons it.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      s_valid = 1'b1; s_data = vecs[0].data[0]; s_last = 1'b0;
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      check("pre_rst_count", byte_count, 32'd4);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
      check("mid_rst_count", byte_count, 32'd0);
      check("mid_rst_crc_valid", {31'd0, crc_valid}, 32'd0);
      check("mid_rst_crc_value", crc_value, 32'd0);
      check("mid_rst_err", {31'd0, err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_vec(vecs[0], 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
